// File: rtl/music_mem_loader.sv
// music_mem_loader: receives a song over a valid/ready byte stream and writes it
// into a 256x8 music memory. The stream is one note-count byte N followed by
// 2N data bytes, which alternate note code and duration.
// Optional feature macro: MUSIC_LOADER_CHECKSUM_EN adds a trailing XOR checksum
// byte covering N and all data bytes. A mismatch aborts the load.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for start; no load has run since reset
// LEN   | waiting for the note-count byte N
// DATA  | receiving 2N note/duration bytes and writing them to memory
// CSUM  | waiting for the checksum byte (MUSIC_LOADER_CHECKSUM_EN only)
// DONE  | last load succeeded; load_done held until the next start
// ERR   | last load aborted; load_error held until the next start
module music_mem_loader #(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int MAX_NOTES      = 128
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] byte_in,
  input  logic       byte_valid,
  output logic       byte_ready,
  output logic       mem_we,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  output logic       busy,
  output logic       load_done,
  output logic       load_error,
  output logic [6:0] song_len
);

  localparam int             TW      = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0]  TO_LOAD = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [8:0]     MAX_N9  = 9'(MAX_NOTES);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LEN  = 3'd1,
    DATA = 3'd2,
`ifdef MUSIC_LOADER_CHECKSUM_EN
    CSUM = 3'd3,
`endif
    DONE = 3'd4,
    ERR  = 3'd5
  } state_t;

  state_t     state;
  state_t     next_state;

  logic [TW-1:0] to_cnt;
  logic [7:0]    byte_cnt;
  logic [6:0]    n_m1;

  logic accept;
  logic start_load;
  logic len_ok;
  logic last_byte;
  logic to_zero;
  logic enter_done;

`ifdef MUSIC_LOADER_CHECKSUM_EN
  logic [7:0] csum;
  logic       csum_ok;
`endif

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode and handshake/status outputs.
  always_comb begin
    next_state = state;
    byte_ready = 1'b0;
    busy       = 1'b0;
    load_done  = 1'b0;
    load_error = 1'b0;
    start_load = 1'b0;
    len_ok     = (byte_in != 8'd0) && ({1'b0, byte_in} <= MAX_N9);
    // The final data byte sits at address 2N-1 = {N-1, 1}; comparing against
    // that avoids needing a 9-bit byte counter for N = 128.
    last_byte  = (byte_cnt == {n_m1, 1'b1});
    to_zero    = (to_cnt == '0);
`ifdef MUSIC_LOADER_CHECKSUM_EN
    csum_ok    = (byte_in == csum);
`endif
    case (state)
      IDLE, DONE, ERR: begin
        load_done  = (state == DONE);
        load_error = (state == ERR);
        if (start) begin
          start_load = 1'b1;
          next_state = LEN;
        end
      end
      LEN: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
        if (byte_valid) begin
          next_state = len_ok ? DATA : ERR;
        end else if (to_zero) begin
          next_state = ERR;
        end
      end
      DATA: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
        if (byte_valid) begin
          if (last_byte) begin
`ifdef MUSIC_LOADER_CHECKSUM_EN
            next_state = CSUM;
`else
            next_state = DONE;
`endif
          end
        end else if (to_zero) begin
          next_state = ERR;
        end
      end
`ifdef MUSIC_LOADER_CHECKSUM_EN
      CSUM: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
        if (byte_valid) begin
          next_state = csum_ok ? DONE : ERR;
        end else if (to_zero) begin
          next_state = ERR;
        end
      end
`endif
      default: begin
        next_state = IDLE;
      end
    endcase
    accept     = byte_ready & byte_valid;
    enter_done = (next_state == DONE) && (state != DONE);
  end

  // Idle-gap timer: reloads on load start and on every accepted byte, then
  // counts down; the terminal count is only acted on when no byte arrives.
  always_ff @(posedge clock) begin
    if (reset) begin
      to_cnt <= '0;
    end else if (start_load || accept) begin
      to_cnt <= TO_LOAD;
    end else if (busy && !to_zero) begin
      to_cnt <= to_cnt - 1'b1;
    end
  end

  // Note count capture and data byte addressing.
  always_ff @(posedge clock) begin
    if (reset) begin
      byte_cnt <= 8'd0;
      n_m1     <= 7'd0;
    end else if (start_load) begin
      byte_cnt <= 8'd0;
    end else if (accept) begin
      if (state == LEN && len_ok) begin
        n_m1 <= 7'(byte_in - 8'd1);
      end
      // Holding on the last byte keeps the counter from wrapping at N = 128.
      if (state == DATA && !last_byte) begin
        byte_cnt <= byte_cnt + 8'd1;
      end
    end
  end

  // Memory write port: one registered write per accepted data byte.
  always_ff @(posedge clock) begin
    if (reset) begin
      mem_we    <= 1'b0;
      mem_addr  <= 8'd0;
      mem_wdata <= 8'd0;
    end else begin
      mem_we <= 1'b0;
      if (accept && state == DATA) begin
        mem_we    <= 1'b1;
        mem_addr  <= byte_cnt;
        mem_wdata <= byte_in;
      end
    end
  end

  // Song length only updates on a successful load.
  always_ff @(posedge clock) begin
    if (reset) begin
      song_len <= 7'd0;
    end else if (enter_done) begin
      song_len <= n_m1;
    end
  end

`ifdef MUSIC_LOADER_CHECKSUM_EN
  // Running XOR over the count byte and every data byte.
  always_ff @(posedge clock) begin
    if (reset || start_load) begin
      csum <= 8'd0;
    end else if (accept && (state == LEN || state == DATA)) begin
      csum <= csum ^ byte_in;
    end
  end
`endif

endmodule
